mpu_reg_dump: RTL and testbench

MPU_REG_DUMP -- requirements
Module: mpu_reg_dump

---
 rtl/mpu_reg_dump.sv | 106 ++++++++++
 tb/tb_mpu_reg_dump.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mpu_reg_dump.sv
// Register dump engine: streams an index byte followed by the 8 little-endian bytes
// of each register in [first_idx, last_idx], snapshotting each register before it is sent.
module mpu_reg_dump (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        start,
   input  logic [4:0]  first_idx,
   input  logic [4:0]  last_idx,
   output logic [4:0]  r_idx,
   input  logic [63:0] r_data,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {IDLE, LATCH, SEND_IDX, SEND_DATA, DONE} state_t;

   state_t      state_q, state_d;
   logic [4:0]  r_idx_q, r_idx_d;
   logic [4:0]  last_q, last_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [63:0] snap_q, snap_d;
   logic        err_q, err_d;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= IDLE;
         r_idx_q <= 5'd0;
         last_q  <= 5'd0;
         cnt_q   <= 3'd0;
         snap_q  <= 64'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         r_idx_q <= r_idx_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         snap_q  <= snap_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      r_idx_d  = r_idx_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      snap_d   = snap_q;
      err_d    = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'd0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (first_idx <= last_idx) begin
                  r_idx_d = first_idx;
                  last_d  = last_idx;
                  state_d = LATCH;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         LATCH: begin
            // Freeze the register so later writes cannot tear the bytes in flight.
            snap_d  = r_data;
            state_d = SEND_IDX;
         end
         SEND_IDX: begin
            tx_valid = 1'b1;
            tx_data  = {3'b000, r_idx_q};
            if (tx_ready) begin
               cnt_d   = 3'd0;
               state_d = SEND_DATA;
            end
         end
         SEND_DATA: begin
            tx_valid = 1'b1;
            tx_data  = snap_q[{cnt_q, 3'b000} +: 8];
            if (tx_ready) begin
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  // Compare before incrementing so index 31 never wraps to 0.
                  if (r_idx_q == last_q) begin
                     state_d = DONE;
                  end else begin
                     r_idx_d = r_idx_q + 5'd1;
                     state_d = LATCH;
                  end
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign r_idx = r_idx_q;
   assign busy  = (state_q != IDLE);
   assign done  = (state_q == DONE);
   assign err   = err_q;

endmodule

// File: tb/tb_mpu_reg_dump.sv
// Bench for mpu_reg_dump: directed cases plus randomized dumps checked against
// a byte-queue model built from a register-file array.
module tb_mpu_reg_dump;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        start = 1'b0;
   logic [4:0]  first_idx = 5'd0;
   logic [4:0]  last_idx = 5'd0;
   logic [4:0]  r_idx;
   logic [63:0] r_data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        busy, done, err;

   logic [63:0] regs [32];
   int total = 0;
   int passed = 0;
   int failed = 0;

   always #5 sys_clk = ~sys_clk;

   assign r_data = regs[r_idx];

   mpu_reg_dump dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start),
      .first_idx(first_idx), .last_idx(last_idx), .r_idx(r_idx), .r_data(r_data),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .done(done), .err(err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // mode: 0 = always ready, 1 = ready toggles 1/0, 2 = random ready.
   // poke: overwrite the last register once its index byte is on the bus.
   // noise: wiggle start/indices while busy and assert start during DONE.
   task automatic do_dump(input logic [4:0] f, input logic [4:0] l, input int mode,
                          input bit poke, input bit noise);
      logic [7:0] exp_q[$];
      logic [7:0] got_q[$];
      logic [7:0] stall_data = 8'd0;
      int busy_cnt = 0;
      int budget, poke_at;
      bit seen_done = 0;
      bit stall = 0;
      bit poked = 0;
      for (int i = int'(f); i <= int'(l); i++) begin
         exp_q.push_back(8'(i));
         for (int b = 0; b < 8; b++) exp_q.push_back(regs[i][8*b +: 8]);
      end
      poke_at = exp_q.size() - 9;
      budget  = 40 * exp_q.size() + 20;
      start = 1'b1; first_idx = f; last_idx = l; tx_ready = 1'b0;
      @(negedge sys_clk);
      start = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (busy) busy_cnt++;
         if (stall) begin
            chk("stall_valid", 64'(tx_valid), 64'd1);
            chk("stall_data", 64'(tx_data), 64'(stall_data));
         end
         if (noise) chk("err_while_busy", 64'(err), 64'd0);
         if (done) begin
            seen_done = 1;
            chk("r_idx_end", 64'(r_idx), 64'(l));
            chk("done_txvalid", 64'(tx_valid), 64'd0);
            start = noise; first_idx = 5'd0; last_idx = 5'd0;
            break;
         end
         case (mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ((c % 2) == 0);
            default: tx_ready = 1'($urandom_range(0, 1));
         endcase
         if (poke && !poked && tx_valid && got_q.size() == poke_at) begin
            regs[l] = ~regs[l];
            poked = 1;
         end
         if (tx_valid && tx_ready) got_q.push_back(tx_data);
         stall = tx_valid && !tx_ready;
         stall_data = tx_data;
         if (noise) begin
            start = 1'($urandom);
            first_idx = 5'($urandom);
            last_idx = 5'($urandom);
         end
         @(negedge sys_clk);
      end
      chk("done_seen", 64'(seen_done), 64'd1);
      chk("nbytes", 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("byte%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
      if (mode == 0) chk("busy_cycles", 64'(busy_cnt), 64'(10 * (int'(l) - int'(f) + 1) + 1));
      @(negedge sys_clk);
      start = 1'b0;
      chk("post_done_idle", 64'({busy, done, tx_valid, err}), 64'd0);
   endtask

   initial begin
      int n;
      logic [4:0] f, l;
      for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};

      // Reset held with start asserted.
      sys_rst = 1'b1; start = 1'b1; first_idx = 5'd0; last_idx = 5'd5; tx_ready = 1'b1;
      repeat (2) begin
         @(negedge sys_clk);
         chk("rst_outputs", 64'({r_idx, tx_data, tx_valid, busy, done, err}), 64'd0);
      end
      sys_rst = 1'b0; start = 1'b0;
      @(negedge sys_clk);
      chk("rst_release", 64'({r_idx, tx_data, tx_valid, busy, done, err}), 64'd0);

      // Single register, full throughput.
      regs[0] = 64'haaaa_aaaa_aaaa_aaaa;
      do_dump(5'd0, 5'd0, 0, 0, 0);

      // Backpressure with a write to reg2 after its snapshot.
      regs[1] = 64'hbbbb_bbbb_bbbb_bbbb;
      regs[2] = 64'h0807_0605_0403_0201;
      do_dump(5'd1, 5'd2, 1, 1, 0);

      // Rejected range.
      start = 1'b1; first_idx = 5'd3; last_idx = 5'd1;
      @(negedge sys_clk);
      start = 1'b0;
      chk("bad_err", 64'(err), 64'd1);
      chk("bad_quiet", 64'({busy, tx_valid, done}), 64'd0);
      @(negedge sys_clk);
      chk("bad_err_pulse", 64'(err), 64'd0);
      chk("bad_idle", 64'({busy, tx_valid, done}), 64'd0);

      // Top of the index range.
      do_dump(5'd30, 5'd31, 0, 0, 0);

      // Reset while the fourth data byte is pending.
      start = 1'b1; first_idx = 5'd5; last_idx = 5'd5;
      @(negedge sys_clk);
      start = 1'b0; tx_ready = 1'b1; n = 0;
      for (int c = 0; c < 50; c++) begin
         if (n == 4 && tx_valid) break;
         if (tx_valid) n++;
         @(negedge sys_clk);
      end
      chk("mid_reached", 64'(n), 64'd4);
      chk("mid_byte3", 64'(tx_data), 64'(regs[5][31:24]));
      sys_rst = 1'b1;
      @(negedge sys_clk);
      chk("mid_rst_outputs", 64'({r_idx, tx_data, tx_valid, busy, done, err}), 64'd0);
      sys_rst = 1'b0; tx_ready = 1'b0;
      @(negedge sys_clk);
      chk("mid_rst_idle", 64'({r_idx, tx_data, tx_valid, busy, done, err}), 64'd0);
      do_dump(5'd0, 5'd0, 0, 0, 0);

      // Randomized dumps with random backpressure and start noise.
      repeat (6) begin
         for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
         f = 5'($urandom_range(0, 31));
         l = f + 5'($urandom_range(0, (31 - int'(f)) < 2 ? (31 - int'(f)) : 2));
         do_dump(f, l, 2, 1'($urandom), 1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
